// File: rtl/jk_register_bank_if.sv
// Bus bundle for jk_register_bank: control, data inputs and register outputs.
interface jk_register_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             i_en;
  logic             i_load;
  logic             i_cnt_clr;
  logic [WIDTH-1:0] i_d;
  logic [WIDTH-1:0] i_j;
  logic [WIDTH-1:0] i_k;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_qbar;
  logic [WIDTH-1:0] o_chg;
  logic [CNT_W-1:0] o_tgl_cnt;

  modport master (
    output i_en, i_load, i_cnt_clr, i_d, i_j, i_k,
    input  o_q, o_qbar, o_chg, o_tgl_cnt
  );

  modport slave (
    input  i_en, i_load, i_cnt_clr, i_d, i_j, i_k,
    output o_q, o_qbar, o_chg, o_tgl_cnt
  );
endinterface

// File: rtl/jk_register_bank.sv
// Bank of WIDTH JK flip-flops with clock enable, parallel load, per-bit
// change pulses and a saturating count of edges that toggled any bit.
module jk_register_bank #(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  jk_register_bank_if.slave bus
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_chg;
  logic [CNT_W-1:0] r_tgl_cnt;

  logic [WIDTH-1:0] w_q_next;
  logic             w_tgl_hit;
  logic             w_cnt_sat;

  // Next Q: load wins over JK; JK truth table folds to (Q & ~K) | (~Q & J).
  always_comb begin
    w_q_next = r_q;
    if (bus.i_load) begin
      w_q_next = bus.i_d;
    end else if (bus.i_en) begin
      w_q_next = (r_q & ~bus.i_k) | (~r_q & bus.i_j);
    end
  end

  // One count per edge on which at least one bit sits in toggle mode.
  always_comb begin
    w_tgl_hit = ~bus.i_load & bus.i_en & (|(bus.i_j & bus.i_k));
    w_cnt_sat = (r_tgl_cnt == {CNT_W{1'b1}});
  end

  // Register state and change pulses; reset never raises CHG.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q   <= RST_VAL;
      r_chg <= '0;
    end else begin
      r_q   <= w_q_next;
      r_chg <= w_q_next ^ r_q;
    end
  end

  // Saturating toggle-event counter; clear beats increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tgl_cnt <= '0;
    end else if (bus.i_cnt_clr) begin
      r_tgl_cnt <= '0;
    end else if (w_tgl_hit && !w_cnt_sat) begin
      r_tgl_cnt <= r_tgl_cnt + CNT_W'(1);
    end
  end

  assign bus.o_q       = r_q;
  assign bus.o_qbar    = ~r_q;
  assign bus.o_chg     = r_chg;
  assign bus.o_tgl_cnt = r_tgl_cnt;

endmodule
